// File: rtl/maq_bcd_mod.sv
// Two-digit BCD modulo counter stage (0..MOD-1) with up/down counting, synchronous clear,
// validated parallel load, terminal count and one-cycle carry/load-error pulses.
module maq_bcd_mod #(
   parameter int MOD   = 60,
   parameter int MSD_W = 3
) (
   input  logic             maqs_clock,
   input  logic             maqs_reset,
   input  logic             maqs_enable,
   input  logic             maqs_up,
   input  logic             maqs_clear,
   input  logic             maqs_load,
   input  logic [3:0]       maqs_load_lsd,
   input  logic [MSD_W-1:0] maqs_load_msd,
   output logic [3:0]       maqs_Lsd,
   output logic [MSD_W-1:0] maqs_Msd,
   output logic             maqs_tc,
   output logic             maqs_carry,
   output logic             maqs_load_err
);

   localparam int TOP = MOD - 1;
   localparam logic [3:0]       TOP_LSD = 4'(TOP % 10);
   localparam logic [MSD_W-1:0] TOP_MSD = MSD_W'(TOP / 10);

   generate
      if (MOD < 2 || MOD > 99) begin : g_bad_mod
         $error("maq_bcd_mod: MOD must be in 2..99");
      end
      if ((2 ** MSD_W) <= ((MOD - 1) / 10)) begin : g_bad_msd_w
         $error("maq_bcd_mod: MSD_W too narrow for MOD");
      end
   endgenerate

   logic             at_top;
   logic             at_zero;
   logic             state_legal;
   logic             load_valid;
   logic [3:0]       lsd_nxt;
   logic [MSD_W-1:0] msd_nxt;
   logic             carry_nxt;
   logic             load_err_nxt;

   assign at_top  = (maqs_Lsd == TOP_LSD) && (maqs_Msd == TOP_MSD);
   assign at_zero = (maqs_Lsd == 4'd0) && (maqs_Msd == '0);
   assign maqs_tc = maqs_up ? at_top : at_zero;

   // A value is in range when its tens digit is below the top, or equal with units not past it.
   assign state_legal = (maqs_Lsd <= 4'd9) &&
                        ((maqs_Msd < TOP_MSD) ||
                         ((maqs_Msd == TOP_MSD) && (maqs_Lsd <= TOP_LSD)));
   assign load_valid  = (maqs_load_lsd <= 4'd9) &&
                        ((maqs_load_msd < TOP_MSD) ||
                         ((maqs_load_msd == TOP_MSD) && (maqs_load_lsd <= TOP_LSD)));

   // NOTE: every output of this block is given a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      lsd_nxt      = maqs_Lsd;
      msd_nxt      = maqs_Msd;
      carry_nxt    = 1'b0;
      load_err_nxt = 1'b0;
      if (maqs_clear) begin
         lsd_nxt = 4'd0;
         msd_nxt = '0;
      end else if (maqs_load) begin
         if (load_valid) begin
            lsd_nxt = maqs_load_lsd;
            msd_nxt = maqs_load_msd;
         end else begin
            load_err_nxt = 1'b1;
         end
      end else if (maqs_enable) begin
         if (!state_legal) begin
            lsd_nxt = 4'd0;
            msd_nxt = '0;
         end else if (maqs_up) begin
            if (at_top) begin
               lsd_nxt   = 4'd0;
               msd_nxt   = '0;
               carry_nxt = 1'b1;
            end else if (maqs_Lsd == 4'd9) begin
               lsd_nxt = 4'd0;
               msd_nxt = maqs_Msd + MSD_W'(1);
            end else begin
               lsd_nxt = maqs_Lsd + 4'd1;
            end
         end else begin
            if (at_zero) begin
               lsd_nxt   = TOP_LSD;
               msd_nxt   = TOP_MSD;
               carry_nxt = 1'b1;
            end else if (maqs_Lsd == 4'd0) begin
               lsd_nxt = 4'd9;
               msd_nxt = maqs_Msd - MSD_W'(1);
            end else begin
               lsd_nxt = maqs_Lsd - 4'd1;
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge maqs_clock or negedge maqs_reset) begin
      if (!maqs_reset) begin
         maqs_Lsd      <= 4'd0;
         maqs_Msd      <= '0;
         maqs_carry    <= 1'b0;
         maqs_load_err <= 1'b0;
      end else begin
         maqs_Lsd      <= lsd_nxt;
         maqs_Msd      <= msd_nxt;
         maqs_carry    <= carry_nxt;
         maqs_load_err <= load_err_nxt;
      end
   end

endmodule
